// File: rtl/pixel_fetch_ctrl.sv
// pixel_fetch_ctrl
//   Upstream fetch stage for the tile/character memory controller. It
//   free-runs the raster timing, works out which maze tile and sprite pixel
//   each screen pixel falls on, and hands these to the memory controller.
//   There are two register stages: S1 holds the map RAM address, and S2
//   captures the tile id that the map RAM returns. Sync and blank go through
//   the same two stages, so they stay aligned with o_mem_select.
//
// Ports
//   i_clk           pixel clock
//   i_rst_n         synchronous reset, active low
//   i_char_x/y      sprite top-left, playfield px (latched at frame start)
//   i_char_id       sprite id (latched at frame start)
//   o_map_addr      map RAM cell index, row*MAP_COLS+col (S1)
//   i_map_tile      map RAM data for o_map_addr, captured into S2
//   o_mem_select    11 = char, 01 = map tile, 00 = outside/blank
//   o_address_map   tile id for current pixel
//   o_address_char  sprite id for current pixel
//   o_tile_offset   {py[2:0],px[2:0]} within tile
//   o_char_offset   {dy[2:0],dx[2:0]} within sprite
//   o_hsync/o_vsync active-low syncs, aligned to o_mem_select
//   o_blank_n       1 = active video, aligned to o_mem_select
//   o_frame_start   1-cycle pulse while the counters sit at h=0, v=V_ACTIVE
//
// The default raster parameters give 640x480@60. They can be overridden to
// get a smaller raster with the same structure.

module pixel_fetch_ctrl #(
  parameter int unsigned ORIGIN_X = 208,
  parameter int unsigned ORIGIN_Y = 116,
  parameter int unsigned MAP_COLS = 28,
  parameter int unsigned MAP_ROWS = 31,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_char_x,
  input  logic [7:0] i_char_y,
  input  logic [7:0] i_char_id,
  output logic [9:0] o_map_addr,
  input  logic [7:0] i_map_tile,
  output logic [1:0] o_mem_select,
  output logic [7:0] o_address_map,
  output logic [7:0] o_address_char,
  output logic [5:0] o_tile_offset,
  output logic [5:0] o_char_offset,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_blank_n,
  output logic       o_frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] C_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] C_V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] C_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0] C_V_ACTIVE = 10'(V_ACTIVE);
  localparam logic [9:0] C_HS_FIRST = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] C_HS_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] C_VS_FIRST = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] C_VS_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] C_OX       = 10'(ORIGIN_X);
  localparam logic [9:0] C_OY       = 10'(ORIGIN_Y);
  localparam logic [9:0] C_PF_W     = 10'(MAP_COLS * 8);
  localparam logic [9:0] C_PF_H     = 10'(MAP_ROWS * 8);
  localparam logic [9:0] C_COLS     = 10'(MAP_COLS);

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_MAP  = 2'b01,
    SEL_CHAR = 2'b11
  } sel_e;

  // S0: raster counters and the latched sprite position
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic [7:0] r_cx;
  logic [7:0] r_cy;
  logic [7:0] r_cid;

  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_frame_now;

  always_comb begin
    w_h_next = r_h_cnt + 10'd1;
    w_v_next = r_v_cnt;
    if (r_h_cnt == C_H_LAST) begin
      w_h_next = '0;
      w_v_next = (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + 10'd1;
    end
  end

  assign w_frame_now = (r_h_cnt == '0) && (r_v_cnt == C_V_ACTIVE);

  // o_frame_start is computed from the next counter value. That way the
  // registered pulse lines up with the cycle in which the counters read
  // (0, V_ACTIVE), which is the same cycle the sprite inputs are sampled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_cx          <= '0;
      r_cy          <= '0;
      r_cid         <= '0;
      o_frame_start <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_next;
      r_v_cnt       <= w_v_next;
      o_frame_start <= (w_h_next == '0) && (w_v_next == C_V_ACTIVE);
      if (w_frame_now) begin
        r_cx  <= i_char_x;
        r_cy  <= i_char_y;
        r_cid <= i_char_id;
      end
    end
  end

  // S0 combinational addressing
  logic [9:0] w_px;
  logic [9:0] w_py;
  logic       w_active;
  logic       w_in_pf;
  logic [8:0] w_dx;
  logic [8:0] w_dy;
  logic       w_in_char;
  logic [9:0] w_cell;
  logic       w_hsync_n;
  logic       w_vsync_n;
  sel_e       w_sel;

  assign w_px     = r_h_cnt - C_OX;
  assign w_py     = r_v_cnt - C_OY;
  assign w_active = (r_h_cnt < C_H_ACTIVE) && (r_v_cnt < C_V_ACTIVE);
  assign w_in_pf  = w_active
                 && (r_h_cnt >= C_OX) && (w_px < C_PF_W)
                 && (r_v_cnt >= C_OY) && (w_py < C_PF_H);

  // 9-bit differences: bit 8 set means the pixel is left of/above the
  // sprite. There is no wrap, so a sprite near the right or bottom edge is
  // clipped by the playfield test instead of reappearing on the other side.
  assign w_dx      = {1'b0, w_px[7:0]} - {1'b0, r_cx};
  assign w_dy      = {1'b0, w_py[7:0]} - {1'b0, r_cy};
  assign w_in_char = w_in_pf
                  && !w_dx[8] && (w_dx[7:3] == '0)
                  && !w_dy[8] && (w_dy[7:3] == '0);

  assign w_cell = ({5'd0, w_py[7:3]} * C_COLS) + {5'd0, w_px[7:3]};

  assign w_hsync_n = !((r_h_cnt >= C_HS_FIRST) && (r_h_cnt <= C_HS_LAST));
  assign w_vsync_n = !((r_v_cnt >= C_VS_FIRST) && (r_v_cnt <= C_VS_LAST));

  always_comb begin
    w_sel = SEL_NONE;
    if (w_in_char) begin
      w_sel = SEL_CHAR;
    end else if (w_in_pf) begin
      w_sel = SEL_MAP;
    end
  end

  // S1: map RAM address plus everything that has to wait for the tile id
  sel_e       r1_sel;
  logic [5:0] r1_tile_off;
  logic [5:0] r1_char_off;
  logic [7:0] r1_char_id;
  logic       r1_hsync_n;
  logic       r1_vsync_n;
  logic       r1_blank_n;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r1_sel      <= SEL_NONE;
      o_map_addr  <= '0;
      r1_tile_off <= '0;
      r1_char_off <= '0;
      r1_char_id  <= '0;
      r1_hsync_n  <= 1'b1;
      r1_vsync_n  <= 1'b1;
      r1_blank_n  <= 1'b0;
    end else begin
      r1_sel      <= w_sel;
      o_map_addr  <= w_in_pf ? w_cell : '0;
      r1_tile_off <= w_in_pf ? {w_py[2:0], w_px[2:0]} : '0;
      r1_char_off <= w_in_char ? {w_dy[2:0], w_dx[2:0]} : '0;
      r1_char_id  <= w_in_char ? r_cid : '0;
      r1_hsync_n  <= w_hsync_n;
      r1_vsync_n  <= w_vsync_n;
      r1_blank_n  <= w_active;
    end
  end

  // S2: tile id arrives from map RAM; all outputs registered here
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_mem_select   <= SEL_NONE;
      o_address_map  <= '0;
      o_address_char <= '0;
      o_tile_offset  <= '0;
      o_char_offset  <= '0;
      o_hsync        <= 1'b1;
      o_vsync        <= 1'b1;
      o_blank_n      <= 1'b0;
    end else begin
      o_mem_select   <= r1_sel;
      o_address_map  <= (r1_sel != SEL_NONE) ? i_map_tile : '0;
      o_address_char <= r1_char_id;
      o_tile_offset  <= r1_tile_off;
      o_char_offset  <= r1_char_off;
      o_hsync        <= r1_hsync_n;
      o_vsync        <= r1_vsync_n;
      o_blank_n      <= r1_blank_n;
    end
  end

endmodule
